clock_ctrl: RTL and testbench

Parametrised successor to the board-level fixed clock divider. It generates the slow processor clock `clk_div` and a matching single-cycle `tick` enable from the board clock, with three modes:
- free-run;
- single-step, one period per debounced key press;
- halt.

It also supports a runtime-loadable divisor and a tick counter for the LCD/JTAG debug path. It sits in the board wrapper between `CLOCK_50` and the `top` instance's slow clock input.

---
 rtl/clock_ctrl_pkg.sv | 18 +
 rtl/key_debounce.sv | 53 +++++
 rtl/clock_ctrl.sv | 137 +++++++++++++
 tb/tb_clock_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_ctrl_pkg.sv
// Shared types and constants for the slow-clock generator and its key debouncer.
package clock_ctrl_pkg;

    typedef enum logic [1:0] {
        ModeRun  = 2'b00,
        ModeStep = 2'b01,
        ModeHalt = 2'b10
    } mode_t;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StStepOne
    } state_t;

    localparam int unsigned MIN_DIV = 2;

endpackage

// File: rtl/key_debounce.sv
// Synchronises and debounces an active-low push-button.
// Emits a one-cycle press pulse on each accepted release-to-press transition.
module key_debounce #(
    parameter int unsigned DEB_CYCLES = 500_000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic press
);

    localparam int unsigned CntW = $clog2(DEB_CYCLES);
    localparam logic [CntW-1:0] CntMax = CntW'(DEB_CYCLES - 1);

    logic            sync1_q, sync2_q;
    logic            stable_q, stable_d;
    logic            press_q, press_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            stable_q <= 1'b1;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            sync1_q  <= key_n;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
        end
    end

    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        press_d  = 1'b0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CntMax) begin
                stable_d = sync2_q;
                // Only a 1->0 change (stable was high) counts as a press.
                press_d  = stable_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign press = press_q;

endmodule

// File: rtl/clock_ctrl.sv
// Slow processor clock generator: free-run, single-step and halt modes with a
// runtime-loadable divisor that only takes effect on period boundaries.
module clock_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int unsigned DIV_W       = 26,
    parameter int unsigned DEFAULT_DIV = 25_000_000,
    parameter int unsigned DEB_CYCLES  = 500_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       mode,
    input  logic             step_key,
    input  logic             div_load,
    input  logic [DIV_W-1:0] div_value,
    output logic             clk_div,
    output logic             tick,
    output logic             halted,
    output logic [31:0]      tick_count
);

    localparam logic [DIV_W-1:0] DefDiv = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] MinDiv = DIV_W'(MIN_DIV);

    state_t           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] div_pend_q, div_pend_d;
    logic             pend_v_q, pend_v_d;
    logic             clk_div_q, clk_div_d;
    logic             tick_q, tick_d;
    logic             halted_q, halted_d;
    logic [31:0]      tick_count_q, tick_count_d;

    logic             step_req;
    logic             at_bound;
    logic             apply;
    logic [DIV_W-1:0] n_next;

    key_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_key_debounce (
        .clk  (clk),
        .reset(reset),
        .key_n(step_key),
        .press(step_req)
    );

    assign at_bound = (cnt_q == div_q - 1'b1);
    // A parked counter has no period to protect, so a pending divisor lands at once.
    assign apply    = pend_v_q && ((state_q == StIdle) || at_bound);
    assign n_next   = apply ? div_pend_q : div_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            cnt_q        <= DefDiv - 1'b1;
            div_q        <= DefDiv;
            div_pend_q   <= DefDiv;
            pend_v_q     <= 1'b0;
            clk_div_q    <= 1'b0;
            tick_q       <= 1'b0;
            halted_q     <= 1'b1;
            tick_count_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            div_q        <= div_d;
            div_pend_q   <= div_pend_d;
            pend_v_q     <= pend_v_d;
            clk_div_q    <= clk_div_d;
            tick_q       <= tick_d;
            halted_q     <= halted_d;
            tick_count_q <= tick_count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (mode == ModeRun) begin
                    state_d = StRun;
                end else if ((mode == ModeStep) && step_req) begin
                    state_d = StStepOne;
                end
            end
            StRun: begin
                if (at_bound && (mode != ModeRun)) begin
                    state_d = StIdle;
                end
            end
            StStepOne: begin
                if (at_bound) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        div_d      = n_next;
        div_pend_d = div_pend_q;
        pend_v_d   = pend_v_q && !apply;
        if (div_load) begin
            div_pend_d = (div_value < MinDiv) ? MinDiv : div_value;
            pend_v_d   = 1'b1;
        end

        if (state_d == StIdle) begin
            cnt_d = n_next - 1'b1;
        end else if ((state_q == StIdle) || at_bound) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        halted_d  = (state_d == StIdle);
        tick_d    = 1'b0;
        clk_div_d = 1'b0;
        if (state_d != StIdle) begin
            tick_d    = (cnt_d == '0);
            // High for ceil(N/2) cycles starting at the tick.
            clk_div_d = (cnt_d < (n_next - (n_next >> 1)));
        end
        tick_count_d = tick_d ? tick_count_q + 32'd1 : tick_count_q;
    end

    assign clk_div    = clk_div_q;
    assign tick       = tick_q;
    assign halted     = halted_q;
    assign tick_count = tick_count_q;

endmodule

// File: tb/tb_clock_ctrl.sv
// Scoreboard bench for clock_ctrl with N=4 default and an 8-cycle debouncer.
module tb_clock_ctrl;

    localparam int unsigned DIV_W = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [1:0]       mode = 2'b00;
    logic             step_key = 1'b1;
    logic             div_load = 1'b0;
    logic [DIV_W-1:0] div_value = '0;
    logic             clk_div;
    logic             tick;
    logic             halted;
    logic [31:0]      tick_count;

    clock_ctrl #(
        .DIV_W      (DIV_W),
        .DEFAULT_DIV(4),
        .DEB_CYCLES (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .step_key  (step_key),
        .div_load  (div_load),
        .div_value (div_value),
        .clk_div   (clk_div),
        .tick      (tick),
        .halted    (halted),
        .tick_count(tick_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    at;
        string name;
        logic  c;
        logic  t;
        logic  h;
        int    tc;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected outputs after the d-th upcoming rising edge; tc < 0 leaves the count unchecked.
    task automatic want(input int d, input string name, input logic c, input logic t,
                        input logic h, input int tc = -1);
        exp_t e;
        e.at   = cyc + d;
        e.name = name;
        e.c    = c;
        e.t    = t;
        e.h    = h;
        e.tc   = tc;
        sb.push_back(e);
    endtask

    task automatic nxt(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            cur = sb.pop_front();
            checks++;
            if (cur.at != cyc || clk_div !== cur.c || tick !== cur.t || halted !== cur.h ||
                (cur.tc >= 0 && tick_count !== 32'(cur.tc))) begin
                errors++;
                $display("FAIL %s cyc=%0d(exp %0d): got clk_div=%b tick=%b halted=%b count=%0d, want %b %b %b %0d",
                         cur.name, cyc, cur.at, clk_div, tick, halted, tick_count,
                         cur.c, cur.t, cur.h, cur.tc);
            end
        end
    end

    initial begin
        nxt(1);
        want(1, "reset_state", 1'b0, 1'b0, 1'b1, 0);
        nxt(1);

        // Free-run at N=4: 1100 with a tick on each rising edge, first tick right after reset.
        reset = 1'b0;
        mode  = 2'b00;
        for (int i = 1; i <= 8; i++) begin
            want(i, "run_n4", ((i - 1) % 4) < 2, ((i - 1) % 4) == 0, 1'b0, (i - 1) / 4 + 1);
        end
        want(40, "run_count40", 1'b0, 1'b0, 1'b0, 10);
        nxt(40);

        // Divisor 0 clamps to 2; the running N=4 period finishes first.
        div_load  = 1'b1;
        div_value = 8'd0;
        want(1, "clamp_old0", 1'b1, 1'b1, 1'b0, 11);
        want(2, "clamp_old1", 1'b1, 1'b0, 1'b0);
        want(3, "clamp_old2", 1'b0, 1'b0, 1'b0);
        want(4, "clamp_old3", 1'b0, 1'b0, 1'b0, 11);
        want(5, "clamp_n2a", 1'b1, 1'b1, 1'b0, 12);
        want(6, "clamp_n2b", 1'b0, 1'b0, 1'b0);
        want(7, "clamp_n2c", 1'b1, 1'b1, 1'b0, 13);
        want(8, "clamp_n2d", 1'b0, 1'b0, 1'b0);
        nxt(1);
        div_load = 1'b0;
        nxt(7);

        // N=5 gives 11100.
        div_load  = 1'b1;
        div_value = 8'd5;
        want(1, "n5_old0", 1'b1, 1'b1, 1'b0, 14);
        want(2, "n5_old1", 1'b0, 1'b0, 1'b0);
        want(3, "n5_c0", 1'b1, 1'b1, 1'b0, 15);
        want(4, "n5_c1", 1'b1, 1'b0, 1'b0);
        want(5, "n5_c2", 1'b1, 1'b0, 1'b0);
        want(6, "n5_c3", 1'b0, 1'b0, 1'b0);
        want(7, "n5_c4", 1'b0, 1'b0, 1'b0);
        want(8, "n5_wrap", 1'b1, 1'b1, 1'b0, 16);
        nxt(1);
        div_load = 1'b0;
        nxt(7);

        // Load N=6, then halt (mode 11) at cnt=2 and resume.
        div_load  = 1'b1;
        div_value = 8'd6;
        want(1, "n6_old1", 1'b1, 1'b0, 1'b0);
        want(2, "n6_old2", 1'b1, 1'b0, 1'b0);
        want(3, "n6_old3", 1'b0, 1'b0, 1'b0);
        want(4, "n6_old4", 1'b0, 1'b0, 1'b0);
        want(5, "n6_c0", 1'b1, 1'b1, 1'b0, 17);
        want(6, "n6_c1", 1'b1, 1'b0, 1'b0);
        want(7, "n6_c2", 1'b1, 1'b0, 1'b0);
        nxt(1);
        div_load = 1'b0;
        nxt(6);
        mode = 2'b11;
        want(1, "halt_c3", 1'b0, 1'b0, 1'b0);
        want(2, "halt_c4", 1'b0, 1'b0, 1'b0);
        want(3, "halt_c5", 1'b0, 1'b0, 1'b0);
        want(4, "halt_parked", 1'b0, 1'b0, 1'b1, 17);
        want(5, "halt_stay", 1'b0, 1'b0, 1'b1);
        nxt(5);
        mode = 2'b00;
        want(1, "resume_tick", 1'b1, 1'b1, 1'b0, 18);
        want(2, "resume_c1", 1'b1, 1'b0, 1'b0);
        want(3, "resume_c2", 1'b1, 1'b0, 1'b0);
        want(4, "resume_c3", 1'b0, 1'b0, 1'b0);
        nxt(4);

        // Back to N=4, then load 7 at cnt=1: old period ends, then 1111000.
        div_load  = 1'b1;
        div_value = 8'd4;
        want(1, "n4_old4", 1'b0, 1'b0, 1'b0);
        want(2, "n4_old5", 1'b0, 1'b0, 1'b0);
        want(3, "n4_c0", 1'b1, 1'b1, 1'b0, 19);
        want(4, "n4_c1", 1'b1, 1'b0, 1'b0);
        nxt(1);
        div_load = 1'b0;
        nxt(3);
        div_load  = 1'b1;
        div_value = 8'd7;
        want(1, "n7_old2", 1'b0, 1'b0, 1'b0);
        want(2, "n7_old3", 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            want(3 + i, "n7_wave", i < 4, i == 0, 1'b0, (i == 0) ? 20 : -1);
        end
        want(10, "n7_wrap", 1'b1, 1'b1, 1'b0, 21);
        nxt(1);
        div_load = 1'b0;
        nxt(9);

        // Halt (mode 10) with a load pending; the load lands as the counter parks.
        mode      = 2'b10;
        div_load  = 1'b1;
        div_value = 8'd4;
        for (int i = 1; i <= 6; i++) begin
            want(i, "halt7", i < 4, 1'b0, 1'b0);
        end
        want(7, "halt7_parked", 1'b0, 1'b0, 1'b1, 21);
        nxt(1);
        div_load = 1'b0;
        nxt(8);

        // Step mode: a 5-cycle glitch is rejected.
        mode     = 2'b01;
        step_key = 1'b0;
        for (int i = 1; i <= 20; i++) want(i, "bounce_idle", 1'b0, 1'b0, 1'b1, 21);
        nxt(5);
        step_key = 1'b1;
        nxt(15);

        // Clean press: one N=4 period, tick DEB_CYCLES+3 edges after the key falls.
        step_key = 1'b0;
        for (int i = 1; i <= 10; i++) want(i, "step_wait", 1'b0, 1'b0, 1'b1, 21);
        want(11, "step_tick", 1'b1, 1'b1, 1'b0, 22);
        want(12, "step_c1", 1'b1, 1'b0, 1'b0);
        want(13, "step_c2", 1'b0, 1'b0, 1'b0);
        want(14, "step_c3", 1'b0, 1'b0, 1'b0);
        for (int i = 15; i <= 20; i++) want(i, "step_done", 1'b0, 1'b0, 1'b1, 22);
        nxt(20);
        step_key = 1'b1;
        for (int i = 1; i <= 15; i++) want(i, "release_idle", 1'b0, 1'b0, 1'b1, 22);
        nxt(15);

        // Load N=5 while parked, step, then reset at cnt=2 with a load in flight.
        div_load  = 1'b1;
        div_value = 8'd5;
        nxt(1);
        div_load = 1'b0;
        nxt(1);
        step_key = 1'b0;
        for (int i = 1; i <= 10; i++) want(i, "step5_wait", 1'b0, 1'b0, 1'b1, 22);
        want(11, "step5_tick", 1'b1, 1'b1, 1'b0, 23);
        want(12, "step5_c1", 1'b1, 1'b0, 1'b0);
        want(13, "step5_c2", 1'b1, 1'b0, 1'b0);
        nxt(13);
        reset     = 1'b1;
        div_load  = 1'b1;
        div_value = 8'd2;
        step_key  = 1'b1;
        want(1, "mid_reset", 1'b0, 1'b0, 1'b1, 0);
        nxt(1);
        reset    = 1'b0;
        div_load = 1'b0;
        mode     = 2'b00;
        for (int i = 1; i <= 8; i++) begin
            want(i, "post_reset_n4", ((i - 1) % 4) < 2, ((i - 1) % 4) == 0, 1'b0,
                 (i - 1) / 4 + 1);
        end
        nxt(8);

        for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
